// File: rtl/wb_bus_arbiter_if.sv
// Writeback bus bundle between the seven result sources, the arbiter and the register-file write port.
// Build option WB_ARB_LOCK_EN adds the per-source i_lock vector.
interface wb_bus_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int N_SRC  = 7
);
  logic [N_SRC-1:0]  i_req;
  logic [DATA_W-1:0] i_data_0;
  logic [DATA_W-1:0] i_data_1;
  logic [DATA_W-1:0] i_data_2;
  logic [DATA_W-1:0] i_data_3;
  logic [DATA_W-1:0] i_data_4;
  logic [DATA_W-1:0] i_data_5;
  logic [DATA_W-1:0] i_data_6;
  logic [N_SRC-1:0]  o_gnt;
  logic              i_ready;
  logic              o_valid;
  logic [DATA_W-1:0] o_data;
  logic [3:0]        o_sel;
  logic [15:0]       o_busy_cnt;
`ifdef WB_ARB_LOCK_EN
  logic [N_SRC-1:0]  i_lock;
`endif

  // Arbiter side: owns the grant vector and the registered output slot.
  modport master (
`ifdef WB_ARB_LOCK_EN
    input  i_lock,
`endif
    input  i_req,
    input  i_data_0, i_data_1, i_data_2, i_data_3, i_data_4, i_data_5, i_data_6,
    input  i_ready,
    output o_gnt,
    output o_valid,
    output o_data,
    output o_sel,
    output o_busy_cnt
  );

  // Requester/consumer side: the datapath sources plus the write-port sink.
  modport slave (
`ifdef WB_ARB_LOCK_EN
    output i_lock,
`endif
    output i_req,
    output i_data_0, i_data_1, i_data_2, i_data_3, i_data_4, i_data_5, i_data_6,
    output i_ready,
    input  o_gnt,
    input  o_valid,
    input  o_data,
    input  o_sel,
    input  o_busy_cnt
  );
endinterface

// File: rtl/wb_bus_arbiter.sv
// Round-robin arbiter for seven writeback sources feeding one registered valid/ready slot.
// Define WB_ARB_LOCK_EN to let a granted source hold priority for multi-beat writebacks.
module wb_bus_arbiter #(
  parameter int DATA_W = 32,
  parameter int N_SRC  = 7
) (
  input logic             i_clk,
  input logic             i_rst_n,
  wb_bus_arbiter_if.master bus
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } slot_state_e;

  slot_state_e       state_q, state_d;
  logic [2:0]        rr_ptr;
  logic [2:0]        ptr_eff;
  logic [2:0]        search_start;
  logic [3:0]        cand;
  logic              gnt_any;
  logic [2:0]        gnt_idx;
  logic              slot_valid;
  logic              slot_free;
  logic              grant_fire;
  logic [N_SRC-1:0]  gnt_vec;
  logic [DATA_W-1:0] sel_word;
  logic [DATA_W-1:0] data_q;
  logic [3:0]        sel_q;
  logic [15:0]       busy_cnt;

  function automatic logic [2:0] wrap_inc(input logic [2:0] p);
    return (p >= 3'd6) ? 3'd0 : p + 3'd1;
  endfunction

  // A corrupted pointer value of 7 behaves exactly like 0.
  assign ptr_eff    = (rr_ptr > 3'd6) ? 3'd0 : rr_ptr;
  assign slot_valid = (state_q == S_FULL);
  assign slot_free  = !slot_valid || bus.i_ready;

`ifdef WB_ARB_LOCK_EN
  logic lock_hold;
  logic lock_kept;

  // While locked the pointer parks on the owner; once the owner lets go,
  // the search begins just past it so the burst yields to the next source.
  assign lock_kept    = bus.i_req[ptr_eff] && bus.i_lock[ptr_eff];
  assign search_start = (lock_hold && !lock_kept) ? wrap_inc(ptr_eff) : ptr_eff;
`else
  assign search_start = ptr_eff;
`endif

  // NOTE: every variable driven here gets a default before any branch, so no latch can be inferred.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = 3'd0;
    cand    = 4'd0;
    for (int i = 0; i < N_SRC; i++) begin
      cand = {1'b0, search_start} + 4'(i);
      if (cand >= 4'd7) cand = cand - 4'd7;
      if (!gnt_any && bus.i_req[cand[2:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[2:0];
      end
    end
  end

  assign grant_fire = slot_free && gnt_any;

  always_comb begin
    gnt_vec = '0;
    if (i_rst_n && grant_fire) gnt_vec[gnt_idx] = 1'b1;
  end

  // Out-of-range select codes fall through to source 0.
  always_comb begin
    sel_word = bus.i_data_0;
    case (gnt_idx)
      3'd1:    sel_word = bus.i_data_1;
      3'd2:    sel_word = bus.i_data_2;
      3'd3:    sel_word = bus.i_data_3;
      3'd4:    sel_word = bus.i_data_4;
      3'd5:    sel_word = bus.i_data_5;
      3'd6:    sel_word = bus.i_data_6;
      default: sel_word = bus.i_data_0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (grant_fire) state_d = S_FULL;
      S_FULL:  if (bus.i_ready && !grant_fire) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: the datapath word is reset too, since the write port observes o_data=0 straight out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_q <= '0;
      sel_q  <= 4'd0;
    end else if (grant_fire) begin
      data_q <= sel_word;
      sel_q  <= {1'b0, gnt_idx};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_cnt <= 16'd0;
    end else if (slot_valid && !bus.i_ready && (busy_cnt != 16'hFFFF)) begin
      busy_cnt <= busy_cnt + 16'd1;
    end
  end

`ifdef WB_ARB_LOCK_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_ptr    <= 3'd0;
      lock_hold <= 1'b0;
    end else if (grant_fire) begin
      if (bus.i_lock[gnt_idx]) begin
        rr_ptr    <= gnt_idx;
        lock_hold <= 1'b1;
      end else begin
        rr_ptr    <= wrap_inc(gnt_idx);
        lock_hold <= 1'b0;
      end
    end else if (lock_hold && !lock_kept) begin
      rr_ptr    <= wrap_inc(ptr_eff);
      lock_hold <= 1'b0;
    end
  end
`else
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_ptr <= 3'd0;
    end else if (grant_fire) begin
      rr_ptr <= wrap_inc(gnt_idx);
    end
  end
`endif

  assign bus.o_gnt      = gnt_vec;
  assign bus.o_valid    = slot_valid;
  assign bus.o_data     = data_q;
  assign bus.o_sel      = sel_q;
  assign bus.o_busy_cnt = busy_cnt;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench for wb_bus_arbiter: stimulus pushes expected beats into a queue,
// a negedge monitor pops and compares each accepted output beat.
module tb_wb_bus_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  wb_bus_arbiter_if #(.DATA_W(32), .N_SRC(7)) bus ();

  wb_bus_arbiter #(.DATA_W(32), .N_SRC(7)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.master)
  );

  logic [31:0] data_val [7];
  logic [6:0]  lock_val;

  assign bus.i_data_0 = data_val[0];
  assign bus.i_data_1 = data_val[1];
  assign bus.i_data_2 = data_val[2];
  assign bus.i_data_3 = data_val[3];
  assign bus.i_data_4 = data_val[4];
  assign bus.i_data_5 = data_val[5];
  assign bus.i_data_6 = data_val[6];
`ifdef WB_ARB_LOCK_EN
  assign bus.i_lock = lock_val;
`endif

  typedef struct packed {
    logic [3:0]  sel;
    logic [31:0] data;
  } beat_t;

  beat_t sb[$];
  beat_t mon_exp;
  int    errors = 0;
  int    checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] onehot_idx(input logic [6:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 7; i++) if (v[i]) r = 4'(i);
    return r;
  endfunction

  // Drive one cycle of inputs just after the edge, then check the same-cycle grant.
  task automatic step(input logic [6:0] req, input logic ready, input logic [6:0] lock,
                      input logic [6:0] exp_gnt, input string name);
    beat_t b;
    @(posedge clk);
    #1;
    bus.i_req   = req;
    bus.i_ready = ready;
    lock_val    = lock;
    #1;
    check(name, 64'(bus.o_gnt), 64'(exp_gnt));
    if (exp_gnt != 7'd0) begin
      b.sel  = onehot_idx(exp_gnt);
      b.data = data_val[onehot_idx(exp_gnt)];
      sb.push_back(b);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.o_valid === 1'b1 && bus.i_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL beat_unexpected: got sel=%0d data=%0h expected no beat", bus.o_sel, bus.o_data);
      end else begin
        mon_exp = sb.pop_front();
        check("beat_sel", 64'(bus.o_sel), 64'(mon_exp.sel));
        check("beat_data", 64'(bus.o_data), 64'(mon_exp.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 7; k++) data_val[k] = 32'hA0 + 32'(k);
    bus.i_req   = 7'h7F;
    bus.i_ready = 1'b1;
    lock_val    = 7'h00;

    // Asynchronous reset before any clock edge; grant must stay low despite requests.
    #1 rst_n = 1'b0;
    #1;
    check("rst_valid", 64'(bus.o_valid), 64'd0);
    check("rst_data", 64'(bus.o_data), 64'd0);
    check("rst_sel", 64'(bus.o_sel), 64'd0);
    check("rst_busy", 64'(bus.o_busy_cnt), 64'd0);
    check("rst_gnt", 64'(bus.o_gnt), 64'd0);
    bus.i_req = 7'h00;
    @(negedge clk);
    rst_n = 1'b1;

    // Fairness: all requesting, grants rotate 0..6 twice.
    for (int i = 0; i < 14; i++)
      step(7'h7F, 1'b1, 7'h00, 7'(1 << (i % 7)), "fair_gnt");

    // Wrap: grant 4 leaves the pointer at 5, then sources 0 and 1, pointer ends at 2.
    step(7'h10, 1'b1, 7'h00, 7'h10, "wrap_set4");
    step(7'h03, 1'b1, 7'h00, 7'h01, "wrap_gnt0");
    step(7'h03, 1'b1, 7'h00, 7'h02, "wrap_gnt1");
    step(7'h7F, 1'b1, 7'h00, 7'h04, "wrap_ptr2");

    // Drain: slot empties, last word and select retained.
    step(7'h00, 1'b1, 7'h00, 7'h00, "drain_gnt");
    step(7'h00, 1'b1, 7'h00, 7'h00, "idle_gnt");
    check("drain_valid", 64'(bus.o_valid), 64'd0);
    check("drain_sel_hold", 64'(bus.o_sel), 64'd2);
    check("drain_data_hold", 64'(bus.o_data), 64'hA2);

    // Backpressure: DEADBEEF held for three stalled cycles, then source 2 granted on release.
    data_val[3] = 32'hDEAD_BEEF;
    step(7'h08, 1'b1, 7'h00, 7'h08, "bp_load");
    for (int i = 0; i < 3; i++) begin
      step(7'h04, 1'b0, 7'h00, 7'h00, "bp_gnt_low");
      check("bp_valid", 64'(bus.o_valid), 64'd1);
      check("bp_data_hold", 64'(bus.o_data), 64'hDEAD_BEEF);
    end
    step(7'h04, 1'b1, 7'h00, 7'h04, "bp_release_gnt");
    check("bp_busy_cnt", 64'(bus.o_busy_cnt), 64'd3);

    // Back-to-back: sources 0 then 6 with no bubble on o_valid.
    step(7'h01, 1'b1, 7'h00, 7'h01, "b2b_gnt0");
    check("b2b_valid_a", 64'(bus.o_valid), 64'd1);
    step(7'h40, 1'b1, 7'h00, 7'h40, "b2b_gnt6");
    check("b2b_valid_b", 64'(bus.o_valid), 64'd1);
    step(7'h00, 1'b1, 7'h00, 7'h00, "b2b_tail");
    check("b2b_no_bubble", 64'(bus.o_valid), 64'd1);
    step(7'h00, 1'b1, 7'h00, 7'h00, "b2b_drain");
    check("b2b_empty", 64'(bus.o_valid), 64'd0);

`ifdef WB_ARB_LOCK_EN
    // Lock: source 0 keeps priority for three beats, then yields to source 1.
    for (int i = 0; i < 3; i++)
      step(7'h03, 1'b1, 7'h01, 7'h01, "lock_gnt0");
    step(7'h03, 1'b1, 7'h00, 7'h02, "lock_release_gnt1");
    step(7'h00, 1'b1, 7'h00, 7'h00, "lock_drain");
    step(7'h00, 1'b1, 7'h00, 7'h00, "lock_idle");
`endif

    // Reset mid-transfer: stalled word is dropped, counters clear, arbitration restarts at 0.
    step(7'h20, 1'b0, 7'h00, 7'h20, "pre_rst_gnt5");
    @(posedge clk);
    #1;
    bus.i_req = 7'h20;
    #1;
    check("pre_rst_valid", 64'(bus.o_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus.o_valid), 64'd0);
    check("mid_rst_data", 64'(bus.o_data), 64'd0);
    check("mid_rst_sel", 64'(bus.o_sel), 64'd0);
    check("mid_rst_busy", 64'(bus.o_busy_cnt), 64'd0);
    check("mid_rst_gnt", 64'(bus.o_gnt), 64'd0);
    sb.delete();
    bus.i_req   = 7'h00;
    bus.i_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    step(7'h48, 1'b1, 7'h00, 7'h08, "post_rst_gnt3");
    step(7'h00, 1'b1, 7'h00, 7'h00, "post_rst_drain");
    step(7'h00, 1'b1, 7'h00, 7'h00, "post_rst_idle");

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
